// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch channel: level request/address out, data/valid back.
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        valid;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  valid
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output valid
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction from imem, holds it
// for the decoder/datapath until retirement, then selects the next PC from jump/branch/zero.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  instr_fetch_if.master    imem,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             stall,
  input  logic             jump,
  input  logic             branch,
  input  logic             zero,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [0:0] {StFetch, StIssue} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pc_plus4_q, pc_plus4_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  // Keeps imem_req low until the first clock edge after reset release.
  logic               req_en_q;
  logic [31:0]        next_pc;
  logic [31:0]        br_off;

  // Next-PC selection; jump wins over a taken branch.
  always_comb begin
    br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (jump) begin
      next_pc = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4_q + br_off;
    end else begin
      next_pc = pc_plus4_q;
    end
  end

  // FSM next-state, datapath register updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_plus4_d  = pc_plus4_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    imem.req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem.req = req_en_q;
        // Responses are only accepted while a request is actually outstanding.
        if (req_en_q && imem.valid) begin
          instr_d = imem.rdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        instr_valid = 1'b1;
        if (!stall) begin
          pc_d       = next_pc;
          pc_plus4_d = next_pc + 32'd4;
          retired_d  = retired_q + CNT_W'(1);
          state_d    = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
      instr_q    <= 32'h0;
      retired_q  <= '0;
      req_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      retired_q  <= retired_d;
      req_en_q   <= 1'b1;
    end
  end

  assign imem.addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_plus4_q;
  assign instr     = instr_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a simple wait-state instruction memory model.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;

  int          checks = 0;
  int          errors = 0;
  int          exp_ret = 0;

  logic [31:0] mem [0:1023];
  int          mem_wait = 0;
  int          wait_ctr;
  logic        force_valid = 1'b0;

  instr_fetch_if imem ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .stall       (stall),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  // Memory answers after mem_wait cycles of held request; force_valid injects stray pulses.
  assign imem.rdata = mem[imem.addr[11:2]];
  assign imem.valid = force_valid || (imem.req && (wait_ctr >= mem_wait));

  always @(posedge clk or posedge reset) begin
    if (reset) wait_ctr <= 0;
    else if (imem.req && !imem.valid) wait_ctr <= wait_ctr + 1;
    else wait_ctr <= 0;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (imem.req !== 1'b0) begin
      errors++; $display("FAIL reset_req got %0b want 0", imem.req);
    end
    checks++;
    if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL reset_pc got %h/%h want 0/4", pc, pc_plus4);
    end
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b0 || retired !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got instr=%h iv=%0b ret=%0d want 0/0/0", instr, instr_valid, retired);
    end
  endtask

  task automatic test_fetch_seq();
    mem_wait = 0;
    reset = 1'b0;
    tick();
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
      errors++; $display("FAIL seq_first got req=%0b addr=%h want 1/0", imem.req, imem.addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== mem[0]) begin
      errors++; $display("FAIL seq_capture got iv=%0b instr=%h want 1/%h", instr_valid, instr, mem[0]);
    end
    tick(); exp_ret++;
    checks++;
    if (imem.addr !== 32'h4 || retired !== 32'd1) begin
      errors++; $display("FAIL seq_addr4 got addr=%h ret=%0d want 4/1", imem.addr, retired);
    end
    tick(); tick(); exp_ret++;
    checks++;
    if (imem.addr !== 32'h8) begin
      errors++; $display("FAIL seq_addr8 got %h want 8", imem.addr);
    end
    tick(); tick(); exp_ret++;
    checks++;
    if (retired !== 32'd3 || pc !== 32'hC) begin
      errors++; $display("FAIL seq_retired got ret=%0d pc=%h want 3/c", retired, pc);
    end
  endtask

  task automatic test_mem_wait();
    tick(); tick(); exp_ret++;
    mem_wait = 3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem.req !== 1'b1 || imem.addr !== 32'h10 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold[%0d] got req=%0b addr=%h iv=%0b want 1/10/0", i, imem.req,
                 imem.addr, instr_valid);
      end
      tick();
    end
    checks++;
    if (instr_valid !== 1'b1 || instr !== mem[4]) begin
      errors++; $display("FAIL wait_capture got iv=%0b instr=%h want 1/%h", instr_valid, instr, mem[4]);
    end
    mem_wait = 0;
    tick(); exp_ret++;
  endtask

  task automatic test_jump();
    tick();
    jump = 1'b1;
    tick(); exp_ret++;
    jump = 1'b0;
    checks++;
    if (imem.addr !== 32'h40) begin
      errors++; $display("FAIL jump_to_40 got %h want 40", imem.addr);
    end
    tick();
    checks++;
    if (pc !== 32'h40 || pc_plus4 !== 32'h44 || instr !== mem[16]) begin
      errors++; $display("FAIL jump_issue got pc=%h p4=%h instr=%h", pc, pc_plus4, instr);
    end
    jump = 1'b1;
    tick(); exp_ret++;
    jump = 1'b0;
    checks++;
    if (imem.addr !== 32'h400 || pc_plus4 !== 32'h404) begin
      errors++; $display("FAIL jump_to_400 got addr=%h p4=%h want 400/404", imem.addr, pc_plus4);
    end
  endtask

  task automatic test_branch();
    mem[256] = {6'h02, 26'h0000010};
    mem[16]  = {6'h04, 10'd0, 16'hFFFE};
    mem[15]  = {6'h02, 26'h0000010};
    mem[17]  = {6'h02, 26'h0000020};
    tick(); jump = 1'b1;
    tick(); exp_ret++; jump = 1'b0;
    tick(); branch = 1'b1; zero = 1'b1;
    tick(); exp_ret++; branch = 1'b0; zero = 1'b0;
    checks++;
    if (imem.addr !== 32'h3C) begin
      errors++; $display("FAIL beq_taken got %h want 3c", imem.addr);
    end
    tick(); jump = 1'b1;
    tick(); exp_ret++; jump = 1'b0;
    tick(); branch = 1'b1; zero = 1'b0;
    tick(); exp_ret++; branch = 1'b0;
    checks++;
    if (imem.addr !== 32'h44) begin
      errors++; $display("FAIL beq_not_taken got %h want 44", imem.addr);
    end
    tick(); jump = 1'b1; branch = 1'b1; zero = 1'b1;
    tick(); exp_ret++; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    checks++;
    if (imem.addr !== 32'h80) begin
      errors++; $display("FAIL jump_priority got %h want 80", imem.addr);
    end
  endtask

  task automatic test_stall();
    mem[32] = 32'h0123_4567;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h0123_4567 || pc !== 32'h80 ||
          retired !== 32'(exp_ret)) begin
        errors++;
        $display("FAIL stall_hold[%0d] got iv=%0b instr=%h pc=%h ret=%0d want 1/01234567/80/%0d",
                 i, instr_valid, instr, pc, retired, exp_ret);
      end
    end
    stall = 1'b0;
    tick(); exp_ret++;
    checks++;
    if (retired !== 32'(exp_ret) || imem.addr !== 32'h84) begin
      errors++;
      $display("FAIL stall_release got ret=%0d addr=%h want %0d/84", retired, imem.addr, exp_ret);
    end
  endtask

  task automatic test_wrap();
    mem[0] = {6'h04, 10'd0, 16'hFFFE};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    exp_ret = 0;
    tick(); branch = 1'b1; zero = 1'b1;
    tick(); exp_ret++; branch = 1'b0; zero = 1'b0;
    checks++;
    if (imem.addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_back got addr=%h p4=%h want fffffffc/0", imem.addr, pc_plus4);
    end
    tick();
    tick(); exp_ret++;
    checks++;
    if (imem.addr !== 32'h0 || retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL wrap_fwd got addr=%h ret=%0d want 0/%0d", imem.addr, retired, exp_ret);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    stall = 1'b1;
    mem[0] = 32'hDEAD_BEEF;
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    checks++;
    if (instr !== {6'h04, 10'd0, 16'hFFFE} || instr_valid !== 1'b1 || pc !== 32'h0) begin
      errors++; $display("FAIL stray_valid got instr=%h iv=%0b pc=%h", instr, instr_valid, pc);
    end
    stall = 1'b0;
    tick(); exp_ret++;
    mem_wait = 3;
    tick();
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h4 || retired !== 32'(exp_ret)) begin
      errors++;
      $display("FAIL mid_fetch got req=%0b addr=%h ret=%0d want 1/4/%0d", imem.req, imem.addr,
               retired, exp_ret);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (imem.req !== 1'b0 || pc !== 32'h0 || pc_plus4 !== 32'h4 || retired !== 32'h0 ||
        instr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got req=%0b pc=%h p4=%h ret=%0d instr=%h iv=%0b", imem.req, pc,
               pc_plus4, retired, instr, instr_valid);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got req=%0b addr=%h iv=%0b want 1/0/0", imem.req, imem.addr,
               instr_valid);
    end
    mem_wait = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[5] = {6'h02, 26'h0000010};
    mem[16] = {6'h02, 26'h0000100};
    test_reset();
    test_fetch_seq();
    test_mem_wait();
    test_jump();
    test_branch();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
